fifo_shadow_checker: RTL and testbench
======================================

# fifo_shadow_checker

Synthesizable, parametrised protocol checker for the team's synchronous FIFO. It sits beside the FIFO on the same interface, replays every accepted write and read into an internal shadow model, and compares all FIFO status outputs and read data against that model every cycle. Mismatches are latched into a sticky per-check error vector with a saturating counter and first-error capture. Both simulation and on-chip debug use the same netlist.

## Interface
- DATA_WIDTH, 16: FIFO data width.
- DEPTH, 8: FIFO depth, at least 4, power of two.
- ERR_CNT_WIDTH, 8: error counter width.
- clk  in  1  clock; single clock domain shared with the FIFO.
- rst  in  1  reset, asynchronous, active-high; same reset as the FIFO.
- chk_en  in  1  enables checks; when 0, the model still tracks but no errors are logged.
- clr_err  in  1  synchronous clear of the error state.
- wr_en, rd_en  in  1 each  FIFO requests as driven to the FIFO.
- data_in  in  DATA_WIDTH  FIFO write data.
- data_out  in  DATA_WIDTH  FIFO read data.
- full, empty, almostfull, almostempty, wr_ack, overflow, underflow  in  1 each  FIFO outputs.
- err_vec  out  NUM_CHK  sticky error bit per check.
- err_pulse  out  1  one-cycle pulse on any check failing.
- err_count  out  ERR_CNT_WIDTH  saturating count of cycles with at least one failure.
- first_err_valid  out  1  high once first_err_id holds a valid capture.
- first_err_id  out  4  ID of the first failing check.
- shadow_count  out  $clog2(DEPTH)+1  shadow occupancy.

## Operation
- FIFO contract the checker enforces:
  - A write is accepted when wr_en && !full.
  - A read is accepted when rd_en && !empty.
  - Simultaneous write and read when full: only the read is accepted. When empty: only the write is accepted.
  - wr_ack, overflow and underflow are registered, one cycle after the request.
  - overflow is expected when wr_en && full. underflow is expected when rd_en && empty.
  - data_out is valid one cycle after an accepted read.
  - full = (cnt==DEPTH), empty = (cnt==0), almostfull = (cnt==DEPTH-1), almostempty = (cnt==1).
- Shadow model:
  - Holds the occupancy count cnt, a DEPTH-entry data store with wrapping pointers, and registered expectations exp_wr_ack, exp_ovf, exp_udf, exp_rd_vld and exp_data.
  - cnt changes by +1 on write only, -1 on read only, and is unchanged for both or neither.
- Checks (ID: condition flagged):
  - 0 FULL: full != (cnt==DEPTH).
  - 1 EMPTY: empty != (cnt==0).
  - 2 AFULL: almostfull mismatch.
  - 3 AEMPTY: almostempty mismatch.
  - 4 WRACK: wr_ack != exp_wr_ack.
  - 5 OVF: overflow != exp_ovf.
  - 6 UDF: underflow != exp_udf.
  - 7 DATA: exp_rd_vld && data_out != exp_data.
  - 8 CONFLICT: (full && empty) || (almostfull && almostempty).
- Logging:
  - hit = check vector & {NUM_CHK{chk_en}}.
  - err_vec |= hit.
  - err_count increments by 1 per cycle with |hit and saturates at all-ones.
  - first_err_id captures the lowest-index set bit of the first nonzero hit.
- clr_err zeroes err_vec, err_count and first_err_valid. If a hit occurs in the same cycle as clr_err, the hit is recorded after the clear (the hit wins).
- The shadow model is not affected by chk_en or clr_err.

## Timing
- Reset values are all 0: every output, cnt, pointers and expectations.
- Reset asserted mid-operation clears the model immediately. No check fires in the first cycle after release, because the expectations are 0.
- Status flags are compared against the current cnt in the same cycle.
- Registered expectations are compared in the cycle after the request.
- Every output is registered. A failure sampled at edge N appears on err_vec, err_pulse and err_count after edge N.
- Pointers wrap modulo DEPTH. cnt never exceeds DEPTH and never goes below 0.

## Structure
- Package fifo_chk_pkg holds:
  - chk_id_e, an enum of the nine check IDs above;
  - NUM_CHK = 9;
  - the localparam helper for the count width.
- Sub-module fifo_shadow_model holds cnt, the data store, the pointers and the expectation registers.
- The top level holds check compare, priority encode and logging.

## Test plan
All scenarios use DATA_WIDTH=16 and DEPTH=8.
- Correct FIFO: write 8 words 0x0001..0x0008, then 2 extra writes, then read 8, then 2 extra reads. Required: err_vec=0, err_count=0, shadow_count returns to 0.
- Inject data corruption on the 3rd read (data_out=0xDEAD, expected 0x0003). Required: err_vec[7]=1 one cycle later, first_err_id=7, err_count=1.
- Force full=1 with cnt=7. Required: err_vec[0] and err_vec[2] set, first_err_id=0 (lowest index).
- Suppress overflow on a write while full. Required: err_vec[5]=1. With chk_en=0 the same stimulus gives err_vec=0.
- Hold a constant mismatch for 300 cycles with ERR_CNT_WIDTH=8. Required: err_count saturates at 255. Then assert clr_err with a hit in the same cycle. Required: err_count=1, first_err_valid=1.
- Assert rst while cnt=5. Required: all outputs 0 immediately, and no error in the first cycle after release.

Source files
------------

// File: rtl/fifo_chk_pkg.sv
// fifo_chk_pkg: check IDs and shared sizing helpers for the FIFO shadow checker
package fifo_chk_pkg;
  localparam int NUM_CHK = 9;
  typedef enum logic [3:0] {
    CHK_FULL, CHK_EMPTY, CHK_AFULL, CHK_AEMPTY, CHK_WRACK,
    CHK_OVF, CHK_UDF, CHK_DATA, CHK_CONFLICT
  } chk_id_e;
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic logic [3:0] lowest_set(input logic [NUM_CHK-1:0] v);
    lowest_set = '0;
    for (int i = NUM_CHK - 1; i >= 0; i--)
      if (v[i]) lowest_set = 4'(i);
  endfunction
endpackage

// File: rtl/fifo_shadow_model.sv
// fifo_shadow_model: replays accepted FIFO traffic into occupancy, data store and registered expectations
module fifo_shadow_model
  import fifo_chk_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int CW         = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [CW-1:0]         cnt,
  output logic                  exp_wr_ack,
  output logic                  exp_ovf,
  output logic                  exp_udf,
  output logic                  exp_rd_vld,
  output logic [DATA_WIDTH-1:0] exp_data
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  full_s, empty_s, wr_acc, rd_acc;
  assign full_s  = cnt == CW'(DEPTH);
  assign empty_s = cnt == '0;
  assign wr_acc  = wr_en && !full_s;
  assign rd_acc  = rd_en && !empty_s;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      exp_wr_ack <= 1'b0;
      exp_ovf    <= 1'b0;
      exp_udf    <= 1'b0;
      exp_rd_vld <= 1'b0;
      exp_data   <= '0;
    end else begin
      wr_ptr     <= wr_ptr + PW'(wr_acc);
      rd_ptr     <= rd_ptr + PW'(rd_acc);
      cnt        <= cnt + CW'(wr_acc && !rd_acc) - CW'(rd_acc && !wr_acc);
      exp_wr_ack <= wr_acc;
      exp_ovf    <= wr_en && full_s;
      exp_udf    <= rd_en && empty_s;
      exp_rd_vld <= rd_acc;
      if (rd_acc) exp_data <= mem[rd_ptr];
    end
  end
  // Data store carries no reset; only entries behind a valid read are ever compared.
  always_ff @(posedge clk)
    if (wr_acc) mem[wr_ptr] <= data_in;
endmodule

// File: rtl/fifo_shadow_checker.sv
// fifo_shadow_checker: compares FIFO status and read data against a shadow model, logs sticky errors
module fifo_shadow_checker
  import fifo_chk_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int DEPTH         = 8,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       chk_en,
  input  logic                       clr_err,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic                       full,
  input  logic                       empty,
  input  logic                       almostfull,
  input  logic                       almostempty,
  input  logic                       wr_ack,
  input  logic                       overflow,
  input  logic                       underflow,
  output logic [NUM_CHK-1:0]         err_vec,
  output logic                       err_pulse,
  output logic [ERR_CNT_WIDTH-1:0]   err_count,
  output logic                       first_err_valid,
  output logic [3:0]                 first_err_id,
  output logic [$clog2(DEPTH):0]     shadow_count
);
  localparam int CW = cnt_width(DEPTH);
  logic [CW-1:0]         cnt;
  logic                  exp_wr_ack, exp_ovf, exp_udf, exp_rd_vld;
  logic [DATA_WIDTH-1:0] exp_data;
  logic [NUM_CHK-1:0]    chk, hit;
  logic [3:0]            hit_id;
  logic                  any_hit;
  fifo_shadow_model #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .CW(CW)) u_model (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
    .cnt(cnt), .exp_wr_ack(exp_wr_ack), .exp_ovf(exp_ovf), .exp_udf(exp_udf),
    .exp_rd_vld(exp_rd_vld), .exp_data(exp_data)
  );
  always_comb begin
    chk               = '0;
    chk[CHK_FULL]     = full != (cnt == CW'(DEPTH));
    chk[CHK_EMPTY]    = empty != (cnt == '0);
    chk[CHK_AFULL]    = almostfull != (cnt == CW'(DEPTH - 1));
    chk[CHK_AEMPTY]   = almostempty != (cnt == CW'(1));
    chk[CHK_WRACK]    = wr_ack != exp_wr_ack;
    chk[CHK_OVF]      = overflow != exp_ovf;
    chk[CHK_UDF]      = underflow != exp_udf;
    chk[CHK_DATA]     = exp_rd_vld && (data_out != exp_data);
    chk[CHK_CONFLICT] = (full && empty) || (almostfull && almostempty);
  end
  assign hit          = chk & {NUM_CHK{chk_en}};
  assign any_hit      = |hit;
  assign hit_id       = lowest_set(hit);
  assign shadow_count = cnt;
  // A hit coinciding with clr_err is logged on top of the cleared state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_vec         <= '0;
      err_pulse       <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_id    <= '0;
    end else begin
      err_pulse <= any_hit;
      if (clr_err) begin
        err_vec         <= hit;
        err_count       <= ERR_CNT_WIDTH'(any_hit);
        first_err_valid <= any_hit;
        first_err_id    <= any_hit ? hit_id : '0;
      end else begin
        err_vec   <= err_vec | hit;
        err_count <= (any_hit && !(&err_count)) ? err_count + ERR_CNT_WIDTH'(1) : err_count;
        if (any_hit && !first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_id    <= hit_id;
        end
      end
    end
  end
endmodule

// File: tb/tb_fifo_shadow_checker.sv
// tb_fifo_shadow_checker: directed tests with a behavioural FIFO plus fault-injection knobs
module tb_fifo_shadow_checker;
  logic        clk = 0, rst = 1, chk_en = 1, clr_err = 0, wr_en = 0, rd_en = 0;
  logic [15:0] data_in = '0, data_out;
  logic        full, empty, almostfull, almostempty, wr_ack, overflow, underflow;
  logic [8:0]  err_vec;
  logic        err_pulse, first_err_valid;
  logic [7:0]  err_count;
  logic [3:0]  first_err_id;
  logic [3:0]  shadow_count;
  logic        corrupt_rd = 0, force_full = 0, flip_empty = 0, sup_ovf = 0;
  int          checks = 0, errors = 0;

  logic [3:0]  f_cnt;
  logic [2:0]  f_wp, f_rp;
  logic [15:0] f_mem [8];
  logic        f_wa, f_ra;
  assign f_wa        = wr_en && f_cnt != 8;
  assign f_ra        = rd_en && f_cnt != 0;
  assign full        = (f_cnt == 8) | force_full;
  assign empty       = (f_cnt == 0) ^ flip_empty;
  assign almostfull  = (f_cnt == 7) & !force_full;
  assign almostempty = f_cnt == 1;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      f_cnt <= 0; f_wp <= 0; f_rp <= 0; wr_ack <= 0; overflow <= 0; underflow <= 0; data_out <= 0;
    end else begin
      if (f_wa) begin f_mem[f_wp] <= data_in; f_wp <= f_wp + 1; end
      if (f_ra) begin data_out <= corrupt_rd ? 16'hDEAD : f_mem[f_rp]; f_rp <= f_rp + 1; end
      f_cnt     <= f_cnt + 4'(f_wa && !f_ra) - 4'(f_ra && !f_wa);
      wr_ack    <= f_wa;
      overflow  <= wr_en && f_cnt == 8 && !sup_ovf;
      underflow <= rd_en && f_cnt == 0;
    end
  end

  fifo_shadow_checker #(.DATA_WIDTH(16), .DEPTH(8), .ERR_CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .chk_en(chk_en), .clr_err(clr_err), .wr_en(wr_en), .rd_en(rd_en),
    .data_in(data_in), .data_out(data_out), .full(full), .empty(empty), .almostfull(almostfull),
    .almostempty(almostempty), .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
    .err_vec(err_vec), .err_pulse(err_pulse), .err_count(err_count),
    .first_err_valid(first_err_valid), .first_err_id(first_err_id), .shadow_count(shadow_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic clear;
    clr_err = 1; tick; clr_err = 0;
  endtask

  task automatic write_n(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin wr_en = 1; data_in = base + 16'(i); tick; end
    wr_en = 0;
  endtask

  task automatic read_n(input int n);
    for (int i = 0; i < n; i++) begin rd_en = 1; tick; end
    rd_en = 0;
  endtask

  task automatic test_reset;
    rst = 1; tick; #1;
    checks++; if ({err_vec, err_pulse, err_count, first_err_valid, first_err_id, shadow_count} !== '0) begin errors++; $display("FAIL reset_outputs got vec=%h cnt=%0d sc=%0d want 0", err_vec, err_count, shadow_count); end
    rst = 0; tick;
    checks++; if (err_vec !== 9'h0) begin errors++; $display("FAIL reset_release_vec got %h want 0", err_vec); end
  endtask

  task automatic test_correct;
    write_n(8, 16'h0001);
    checks++; if (shadow_count !== 4'd8) begin errors++; $display("FAIL fill_count got %0d want 8", shadow_count); end
    write_n(2, 16'h0100);
    checks++; if (shadow_count !== 4'd8) begin errors++; $display("FAIL overfill_count got %0d want 8", shadow_count); end
    read_n(10);
    tick;
    checks++; if (err_vec !== 9'h0) begin errors++; $display("FAIL correct_vec got %h want 0", err_vec); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL correct_cnt got %0d want 0", err_count); end
    checks++; if (shadow_count !== 4'd0) begin errors++; $display("FAIL drain_count got %0d want 0", shadow_count); end
  endtask

  task automatic test_back_to_back;
    wr_en = 1; rd_en = 1; data_in = 16'h0050; tick;
    checks++; if (shadow_count !== 4'd1) begin errors++; $display("FAIL wr_rd_empty_count got %0d want 1", shadow_count); end
    rd_en = 0; write_n(2, 16'h0051);
    for (int i = 0; i < 4; i++) begin wr_en = 1; rd_en = 1; data_in = 16'h0060 + 16'(i); tick; end
    wr_en = 0; rd_en = 0;
    checks++; if (shadow_count !== 4'd3) begin errors++; $display("FAIL wr_rd_count got %0d want 3", shadow_count); end
    read_n(3); tick;
    checks++; if (err_vec !== 9'h0 || shadow_count !== 4'd0) begin errors++; $display("FAIL b2b_clean got vec=%h sc=%0d want 0/0", err_vec, shadow_count); end
  endtask

  task automatic test_data_corrupt;
    write_n(8, 16'h0001);
    for (int i = 1; i <= 8; i++) begin
      rd_en = 1; corrupt_rd = (i == 3); tick;
      if (i == 3) begin checks++; if (err_vec !== 9'h0) begin errors++; $display("FAIL data_early got %h want 0", err_vec); end end
      if (i == 4) begin
        checks++; if (err_vec !== 9'h080) begin errors++; $display("FAIL data_vec got %h want 080", err_vec); end
        checks++; if (first_err_valid !== 1'b1 || first_err_id !== 4'd7) begin errors++; $display("FAIL data_first got v=%b id=%0d want 1/7", first_err_valid, first_err_id); end
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL data_pulse got %b want 1", err_pulse); end
      end
      if (i == 5) begin checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL data_pulse_end got %b want 0", err_pulse); end end
    end
    rd_en = 0; corrupt_rd = 0; tick;
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL data_cnt got %0d want 1", err_count); end
    clear;
  endtask

  task automatic test_force_full;
    write_n(7, 16'h0200);
    force_full = 1; tick; force_full = 0;
    checks++; if (err_vec !== 9'h005) begin errors++; $display("FAIL ffull_vec got %h want 005", err_vec); end
    checks++; if (first_err_id !== 4'd0 || first_err_valid !== 1'b1) begin errors++; $display("FAIL ffull_first got v=%b id=%0d want 1/0", first_err_valid, first_err_id); end
    clear;
    checks++; if (err_vec !== 9'h0 || first_err_valid !== 1'b0) begin errors++; $display("FAIL clear_vec got %h v=%b want 0/0", err_vec, first_err_valid); end
  endtask

  task automatic test_overflow;
    write_n(1, 16'h0207);
    wr_en = 1; sup_ovf = 1; tick; wr_en = 0; sup_ovf = 0; tick;
    checks++; if (err_vec !== 9'h020) begin errors++; $display("FAIL ovf_vec got %h want 020", err_vec); end
    clear;
    chk_en = 0;
    wr_en = 1; sup_ovf = 1; tick; wr_en = 0; sup_ovf = 0; tick;
    checks++; if (err_vec !== 9'h0 || err_count !== 8'd0) begin errors++; $display("FAIL ovf_dis got vec=%h cnt=%0d want 0/0", err_vec, err_count); end
    chk_en = 1;
    read_n(8); tick;
    checks++; if (err_vec !== 9'h0 || shadow_count !== 4'd0) begin errors++; $display("FAIL ovf_drain got vec=%h sc=%0d want 0/0", err_vec, shadow_count); end
  endtask

  task automatic test_saturate;
    flip_empty = 1;
    repeat (300) tick;
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_cnt got %0d want 255", err_count); end
    checks++; if (err_vec !== 9'h002 || first_err_id !== 4'd1) begin errors++; $display("FAIL sat_vec got %h id=%0d want 002/1", err_vec, first_err_id); end
    clr_err = 1; tick; clr_err = 0;
    checks++; if (err_count !== 8'd1 || first_err_valid !== 1'b1) begin errors++; $display("FAIL clr_hit got cnt=%0d v=%b want 1/1", err_count, first_err_valid); end
    checks++; if (err_vec !== 9'h002) begin errors++; $display("FAIL clr_hit_vec got %h want 002", err_vec); end
    flip_empty = 0; clear;
    checks++; if (err_count !== 8'd0 || first_err_valid !== 1'b0) begin errors++; $display("FAIL clr_clean got cnt=%0d v=%b want 0/0", err_count, first_err_valid); end
  endtask

  task automatic test_reset_mid;
    write_n(5, 16'h0300);
    checks++; if (shadow_count !== 4'd5) begin errors++; $display("FAIL mid_count got %0d want 5", shadow_count); end
    flip_empty = 1; tick; flip_empty = 0;
    checks++; if (err_vec !== 9'h002) begin errors++; $display("FAIL mid_pre_vec got %h want 002", err_vec); end
    rst = 1; #1;
    checks++; if ({err_vec, err_pulse, err_count, first_err_valid, first_err_id, shadow_count} !== '0) begin errors++; $display("FAIL mid_reset got vec=%h cnt=%0d sc=%0d want 0", err_vec, err_count, shadow_count); end
    tick; rst = 0; tick;
    checks++; if (err_vec !== 9'h0 || err_pulse !== 1'b0 || shadow_count !== 4'd0) begin errors++; $display("FAIL mid_release got vec=%h p=%b sc=%0d want 0", err_vec, err_pulse, shadow_count); end
  endtask

  initial begin
    test_reset;
    test_correct;
    test_back_to_back;
    test_data_corrupt;
    test_force_full;
    test_overflow;
    test_saturate;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
